layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Per-layer control stage that sits directly downstream of the MAC neuron unit and drives it. For each of NUM_NEURONS neurons it presents a neuron index to select weights and bias, pulses the MAC start, waits for MAC completion and captures the MAC result. It then applies the layer activation and writes the value into a registered activation vector that feeds the next layer's `x` input. It also tracks a running argmax for classification at the output layer.

## Interface
Parameters:
- NUM_NEURONS, 10, neurons in this layer (≥1)
- FP_TOTAL_BITS, 16, fixed-point word width; matches MAC output
- FP_FRAC_BITS, 8, fractional bits; informational only, no rescaling here

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- layer_start  input  1  one-cycle request to process the whole layer
- mac_start  output  1  one-cycle start pulse to the MAC
- neuron_idx  output  $clog2(NUM_NEURONS) (min 1)  current neuron; upstream mux selects weights/bias with it
- mac_done  input  1  MAC completion pulse; result is valid on the following cycle
- mac_result  input  FP_TOTAL_BITS signed  MAC Qm.n output
- act_out  output  [NUM_NEURONS] x FP_TOTAL_BITS signed  registered activation vector
- busy  output  1  high from the cycle after an accepted layer_start until layer_done
- layer_done  output  1  one-cycle pulse when all neurons are written
- argmax_idx  output  $clog2(NUM_NEURONS) (min 1)  index of the largest activation
- argmax_val  output  FP_TOTAL_BITS signed  value at argmax_idx

## Operation
- States: IDLE, ISSUE, WAIT_DONE, CAPTURE, FINISH.
- IDLE: if layer_start is high, go to ISSUE. Set neuron_idx=0 and clear the argmax tracker. Otherwise stay.
- ISSUE: assert mac_start for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: hold. When mac_done=1, go to CAPTURE.
- CAPTURE: sample mac_result and apply the activation:
  - write the result to act_out[neuron_idx];
  - update argmax;
  - if neuron_idx==NUM_NEURONS-1, go to FINISH; otherwise increment neuron_idx and go to ISSUE.
- FINISH: layer_done=1 for this cycle, then go to IDLE.
- neuron_idx stays stable from ISSUE through CAPTURE of that neuron. Upstream weight/bias selection must remain valid for the whole MAC computation.
- Argmax rules:
  - the first neuron (idx 0) initializes the tracker unconditionally;
  - later neurons replace it only if strictly greater (signed compare of the post-activation value);
  - ties keep the lower index.
- act_out entries keep old values until overwritten. The vector is fully valid when layer_done pulses.
- No arithmetic beyond activation: width in = width out = FP_TOTAL_BITS.

## Timing
- Reset values:
  - state IDLE;
  - mac_start, busy, layer_done, neuron_idx, argmax_idx all 0;
  - argmax_val 0;
  - every act_out entry 0.
- Reset mid-operation: the next cycle is IDLE with all the above values. A pending MAC result is discarded.
- Cycle timing, with layer_start sampled at edge s and MAC done latency D (mac_done high D cycles after the mac_start cycle):
  - ISSUE for neuron k occurs at cycle s+1+k(D+2);
  - CAPTURE for neuron k occurs at cycle s+1+k(D+2)+D+1;
  - layer_done occurs at s+1+NUM_NEURONS(D+2).
- Per-neuron cost: D+2 cycles.
- busy is high in ISSUE, WAIT_DONE, CAPTURE and FINISH.
- layer_start while busy: ignored, with no restart and no queuing.
- layer_start in the same cycle as FINISH: ignored. The earliest accepted restart is the cycle after layer_done.
- mac_done outside WAIT_DONE: ignored.
- mac_done held high for several cycles: only the first pulse seen in WAIT_DONE counts. The next neuron re-enters WAIT_DONE only after ISSUE.
- NUM_NEURONS=1: ISSUE → WAIT_DONE → CAPTURE → FINISH, with argmax_idx=0.
- act_out[k], argmax_idx and argmax_val update at the edge ending CAPTURE. They are visible from the following cycle.

## Configuration
- LAYER_RELU_EN defined: activation is ReLU, giving act = (mac_result<0) ? 0 : mac_result. Argmax compares the post-ReLU value.
- LAYER_RELU_EN undefined: activation is identity (linear output layer). act = mac_result and argmax compares the raw signed value.
- Control behaviour and timing are identical in both builds.

## Test plan
Unless stated otherwise, the bench uses NUM_NEURONS=4 and a MAC model with D=3.
- ReLU build, results [5,-3,10,10] (Q8.8 raw) → act_out=[5,0,10,10], argmax_idx=2, argmax_val=10. layer_done at cycle s+21, and exactly 4 mac_start pulses at cycles s+1, s+6, s+11, s+16.
- Linear build, same results [5,-3,10,10] → act_out=[5,-3,10,10], argmax_idx=2. Linear build, results [-7,-2,-9,-4] → argmax_idx=1, argmax_val=-2.
- ReLU build, all-negative results [-1,-2,-3,-4] → act_out all 0, argmax_idx=0, argmax_val=0.
- Protocol abuse:
  - layer_start re-pulsed during WAIT_DONE of neuron 1 → ignored, no extra mac_start, layer_done once;
  - mac_done pulsed in IDLE → no state change;
  - mac_done held for 3 cycles → one capture only.
- Reset asserted during WAIT_DONE of neuron 2 → next cycle busy=0, all outputs 0. A new layer_start then runs the full 4-neuron sequence correctly.
- Back-to-back layers: second layer_start the cycle after layer_done, with results [1,2,3,4] after [4,3,2,1] → second run gives argmax_idx=3, so the argmax tracker was cleared.

Source files
------------

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer
// Description : Per-layer controller that drives the MAC neuron unit neuron by
//               neuron, applies the activation, fills the activation vector
//               and tracks a running argmax. Define LAYER_RELU_EN for a ReLU
//               activation; otherwise the activation is identity.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int NUM_NEURONS   = 10,
    parameter int FP_TOTAL_BITS = 16,
    parameter int FP_FRAC_BITS  = 8,
    localparam int c_IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            layer_start,
    output logic                            mac_start,
    output logic [c_IDX_W-1:0]              neuron_idx,
    input  logic                            mac_done,
    input  logic signed [FP_TOTAL_BITS-1:0] mac_result,
    output logic signed [FP_TOTAL_BITS-1:0] act_out [NUM_NEURONS],
    output logic                            busy,
    output logic                            layer_done,
    output logic [c_IDX_W-1:0]              argmax_idx,
    output logic signed [FP_TOTAL_BITS-1:0] argmax_val
);

    localparam int                 c_INT_BITS = FP_TOTAL_BITS - FP_FRAC_BITS;
    localparam int                 c_SIGN_BIT = c_INT_BITS + FP_FRAC_BITS - 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_NEURONS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_CAPTURE   = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_IDX_W-1:0]              r_neuron_idx;
    logic [c_IDX_W-1:0]              r_argmax_idx;
    logic signed [FP_TOTAL_BITS-1:0] r_argmax_val;
    logic signed [FP_TOTAL_BITS-1:0] r_act [NUM_NEURONS];

    logic                            w_start_acc;
    logic                            w_capture;
    logic                            w_last;
    logic signed [FP_TOTAL_BITS-1:0] w_act;
    logic [FP_TOTAL_BITS-1:0]        w_act_ob;
    logic [FP_TOTAL_BITS-1:0]        w_best_ob;
    logic                            w_gt;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mac_start   = 1'b0;
        layer_done  = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (layer_start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mac_start   = 1'b1;
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (mac_done) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = w_last ? S_FINISH : S_ISSUE;
            end
            S_FINISH: begin
                layer_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_start_acc = (r_state == S_IDLE) && layer_start;
    assign w_capture   = (r_state == S_CAPTURE);
    assign w_last      = (r_neuron_idx == c_LAST_IDX);

    // ------------------------------------------------------------------------
    // Activation
    // ------------------------------------------------------------------------
`ifdef LAYER_RELU_EN
    assign w_act = mac_result[c_SIGN_BIT] ? '0 : mac_result;
`else
    assign w_act = mac_result;
`endif

    // Offset-binary form turns the signed compare into an unsigned one.
    assign w_act_ob  = {~w_act[c_SIGN_BIT], w_act[c_SIGN_BIT-1:0]};
    assign w_best_ob = {~r_argmax_val[c_SIGN_BIT], r_argmax_val[c_SIGN_BIT-1:0]};
    assign w_gt      = (w_act_ob > w_best_ob);

    // ------------------------------------------------------------------------
    // Neuron index and argmax tracker
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_neuron_idx <= '0;
        end else if (w_capture && !w_last) begin
            r_neuron_idx <= r_neuron_idx + c_IDX_ONE;
        end
    end

    // Neuron 0 seeds the tracker; strict compare keeps the lower index on ties.
    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_argmax_idx <= '0;
            r_argmax_val <= '0;
        end else if (w_capture && ((r_neuron_idx == '0) || w_gt)) begin
            r_argmax_idx <= r_neuron_idx;
            r_argmax_val <= w_act;
        end
    end

    // ------------------------------------------------------------------------
    // Activation vector
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_act
        always_ff @(posedge clk) begin
            if (reset) begin
                r_act[i] <= '0;
            end else if (w_capture && (r_neuron_idx == c_IDX_W'(i))) begin
                r_act[i] <= w_act;
            end
        end
        assign act_out[i] = r_act[i];
    end

    assign neuron_idx = r_neuron_idx;
    assign argmax_idx = r_argmax_idx;
    assign argmax_val = r_argmax_val;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_sequencer
// Description : Directed and randomized bench for layer_sequencer with a
//               latency-programmable MAC responder and an argmax model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk         = 1'b0;
    logic                reset       = 1'b1;
    logic                layer_start = 1'b0;
    logic                mac_done    = 1'b0;
    logic signed [W-1:0] mac_result  = '0;
    logic                mac_start;
    logic                busy;
    logic                layer_done;
    logic [1:0]          neuron_idx;
    logic [1:0]          argmax_idx;
    logic signed [W-1:0] argmax_val;
    logic signed [W-1:0] act_out [N];

    int ntests = 0;
    int nfail  = 0;
    logic signed [W-1:0] res_q [N];

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_NEURONS  (N),
        .FP_TOTAL_BITS(W),
        .FP_FRAC_BITS (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .layer_start(layer_start),
        .mac_start  (mac_start),
        .neuron_idx (neuron_idx),
        .mac_done   (mac_done),
        .mac_result (mac_result),
        .act_out    (act_out),
        .busy       (busy),
        .layer_done (layer_done),
        .argmax_idx (argmax_idx),
        .argmax_val (argmax_val)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [W-1:0] activ(input logic signed [W-1:0] r);
`ifdef LAYER_RELU_EN
        return (r < 0) ? '0 : r;
`else
        return r;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mac_start"}, mac_start, 0);
        chk({tag, "_layer_done"}, layer_done, 0);
        chk({tag, "_neuron_idx"}, neuron_idx, 0);
        chk({tag, "_argmax_idx"}, argmax_idx, 0);
        chk({tag, "_argmax_val"}, argmax_val, 0);
        for (int i = 0; i < N; i++) chk({tag, "_act_out"}, act_out[i], 0);
    endtask

    // Runs one layer with a MAC of latency d holding mac_done for hold cycles.
    // Cycle c counts edges since the one that sampled layer_start.
    task automatic run_layer(input int d, input int hold, input bit restart_n1,
                             input bit start_in_finish, input bit reset_n2);
        logic signed [W-1:0] act [N];
        logic signed [W-1:0] res_at [0:127];
        bit                  done_at [0:127];
        int best, per, last, c, issued, k;

        for (int i = 0; i < N; i++) act[i] = activ(res_q[i]);
        best = 0;
        for (int i = 1; i < N; i++) if (act[i] > act[best]) best = i;
        per  = d + 2;
        last = 1 + N * per;
        for (int i = 0; i < 128; i++) begin
            done_at[i] = 1'b0;
            res_at[i]  = W'($urandom);
        end
        issued = 0;

        layer_start = 1'b1;
        step();
        c = 1;
        while (c <= last) begin
            layer_start = 1'b0;
            chk("mac_start", mac_start, (c < last) && ((c - 1) % per == 0));
            chk("layer_done", layer_done, c == last);
            chk("busy", busy, 1);
            if (c < last) chk("neuron_idx", neuron_idx, (c - 1) / per);
            if (c > 1 && (c - 1) % per == 0) begin
                k = (c - 1) / per - 1;
                chk("act_out_live", act_out[k], act[k]);
            end
            if (mac_start === 1'b1 && issued < N) begin
                for (int h = 0; h <= hold; h++) begin
                    if (h < hold) done_at[c + d + h] = 1'b1;
                    res_at[c + d + h] = res_q[issued];
                end
                issued++;
            end
            if (restart_n1 && c == 2 + per) layer_start = 1'b1;
            if (start_in_finish && c == last) layer_start = 1'b1;
            mac_done   = done_at[c];
            mac_result = res_at[c];
            if (reset_n2 && c == 2 + 2 * per) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk_all_zero("midreset");
                for (int j = 1; j <= 3; j++) begin
                    mac_done   = done_at[c + j];
                    mac_result = res_at[c + j];
                    step();
                    chk("midreset_idle_busy", busy, 0);
                    chk("midreset_idle_mac_start", mac_start, 0);
                end
                mac_done = 1'b0;
                return;
            end
            step();
            c++;
        end

        layer_start = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_mac_start", mac_start, 0);
        chk("end_layer_done", layer_done, 0);
        for (int i = 0; i < N; i++) chk("end_act_out", act_out[i], act[i]);
        chk("argmax_idx", argmax_idx, best);
        chk("argmax_val", argmax_val, act[best]);
        mac_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();
        chk_all_zero("post_reset");

        // Stray mac_done while idle
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_mac_start", mac_start, 0);
        step();
        chk("idle_done_busy2", busy, 0);
        chk("idle_done_layer_done", layer_done, 0);

        res_q = '{16'sd5, -16'sd3, 16'sd10, 16'sd10};
        run_layer(3, 1, 1'b0, 1'b0, 1'b0);
        step();
        res_q = '{-16'sd7, -16'sd2, -16'sd9, -16'sd4};
        run_layer(3, 1, 1'b0, 1'b0, 1'b0);
        res_q = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4};
        run_layer(3, 1, 1'b0, 1'b0, 1'b0);
        step();

        // Back-to-back: the tracker must clear between layers
        res_q = '{16'sd4, 16'sd3, 16'sd2, 16'sd1};
        run_layer(3, 1, 1'b0, 1'b0, 1'b0);
        res_q = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        run_layer(3, 1, 1'b0, 1'b0, 1'b0);
        step();
        step();

        res_q = '{16'sd8, -16'sd5, 16'sd8, 16'sd2};
        run_layer(3, 1, 1'b1, 1'b1, 1'b0);
        step();
        res_q = '{16'sd3, 16'sd9, -16'sd1, 16'sd6};
        run_layer(3, 3, 1'b0, 1'b0, 1'b0);
        step();
        res_q = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
        run_layer(3, 1, 1'b0, 1'b0, 1'b1);
        res_q = '{-16'sd6, 16'sd12, 16'sd0, 16'sd12};
        run_layer(3, 1, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) begin
                res_q[i] = W'($urandom);
                if (i > 0 && $urandom_range(0, 3) == 0) res_q[i] = res_q[i - 1];
            end
            run_layer(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
